// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// register tags, FSM states, forwarding codes and branch classes.
package hazard_pkg;

    localparam logic [3:0] NO_REG = 4'hF;

    typedef enum logic {
        RUN,
        RESOLVE
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EQZ  = 3'd1;
    localparam logic [2:0] NEZ  = 3'd2;
    localparam logic [2:0] TEQZ = 3'd3;
    localparam logic [2:0] TNEZ = 3'd4;
    localparam logic [2:0] JUMP = 3'd5;
    localparam logic [2:0] DB   = 3'd6;

    typedef struct packed {
        logic [3:0] dest;
        logic       is_load;
    } tag_t;

    localparam tag_t BUBBLE = '{dest: NO_REG, is_load: 1'b0};

    // Register 0 is real, so the use bit gates the compare; NO_REG never matches.
    function automatic logic src_match(input logic used, input logic [3:0] src, input tag_t t);
        return used && (t.dest != NO_REG) && (t.dest == src);
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Three-stage destination tag shift register (EX, MEM, WB) that mirrors
// the datapath; a bubble replaces the ID tag when the ID slot is not issued.
module hazard_tag_pipe
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  tag_t id_tag,
    input  logic bubble,
    output tag_t ex_tag,
    output tag_t mem_tag,
    output tag_t wb_tag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag  <= BUBBLE;
            mem_tag <= BUBBLE;
            wb_tag  <= BUBBLE;
        end else begin
            ex_tag  <= bubble ? BUBBLE : id_tag;
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: data-hazard stall/forward, branch flush FSM, stall counter.
// Define HAZARD_FORWARD_EN for forwarding with load-use stalls; otherwise stall until the writer retires.
module hazard_controller
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_registerX,
    input  logic [3:0]  id_registerY,
    input  logic        id_useX,
    input  logic        id_useY,
    input  logic [3:0]  id_registerZ,
    input  logic        id_isLoad,
    input  logic [2:0]  jumpControl,
    input  logic        ex_taken,
    output logic        stall,
    output logic        flush,
    output logic [1:0]  fwdX,
    output logic [1:0]  fwdY,
    output logic [15:0] stallCount
);

    state_t      state;
    tag_t        id_tag;
    tag_t        ex_tag;
    tag_t        mem_tag;
    tag_t        wb_tag;
    logic [15:0] stall_cnt;
    logic        flush_int;
    logic        hazard;
    logic        stall_int;
    logic        id_bubble;
    logic [1:0]  fwd_x_int;
    logic [1:0]  fwd_y_int;
    logic        ex_x, ex_y, mem_x, mem_y, wb_x, wb_y;
    logic        unused_load_bits;

    assign ex_x  = src_match(id_useX, id_registerX, ex_tag);
    assign ex_y  = src_match(id_useY, id_registerY, ex_tag);
    assign mem_x = src_match(id_useX, id_registerX, mem_tag);
    assign mem_y = src_match(id_useY, id_registerY, mem_tag);
    assign wb_x  = src_match(id_useX, id_registerX, wb_tag);
    assign wb_y  = src_match(id_useY, id_registerY, wb_tag);

    assign unused_load_bits = ^{ex_tag.is_load, mem_tag.is_load, wb_tag.is_load};

    // ex_taken is only meaningful while the branch sits in EX.
    assign flush_int = (state == RESOLVE) && ex_taken;

`ifdef HAZARD_FORWARD_EN
    assign hazard = (ex_x || ex_y) && ex_tag.is_load;

    // Youngest producer wins: EX over MEM over WB.
    always_comb begin
        fwd_x_int = FWD_RF;
        fwd_y_int = FWD_RF;
        if (ex_x)       fwd_x_int = FWD_EX;
        else if (mem_x) fwd_x_int = FWD_MEM;
        else if (wb_x)  fwd_x_int = FWD_WB;
        if (ex_y)       fwd_y_int = FWD_EX;
        else if (mem_y) fwd_y_int = FWD_MEM;
        else if (wb_y)  fwd_y_int = FWD_WB;
    end
`else
    assign hazard    = ex_x || ex_y || mem_x || mem_y || wb_x || wb_y;
    assign fwd_x_int = FWD_RF;
    assign fwd_y_int = FWD_RF;
`endif

    // A flushed instruction cannot be stalled, so flush overrides stall.
    assign stall_int = hazard && !flush_int;
    assign id_bubble = !id_valid || stall_int || flush_int;
    assign id_tag    = '{dest: id_registerZ, is_load: id_isLoad};

    hazard_tag_pipe u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .id_tag  (id_tag),
        .bubble  (id_bubble),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag)
    );

    // RESOLVE always lasts one cycle, so a branch in ID then never re-enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (id_valid && (jumpControl != IDLE) && !stall_int && !flush_int)
                        state <= RESOLVE;
                end
                RESOLVE: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_int && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall      = !rst && stall_int;
    assign flush      = !rst && flush_int;
    assign fwdX       = rst ? FWD_RF : fwd_x_int;
    assign fwdY       = rst ? FWD_RF : fwd_y_int;
    assign stallCount = rst ? 16'd0 : stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; adapts expectations to HAZARD_FORWARD_EN.
module tb_hazard_controller;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid;
    logic [3:0]  id_registerX;
    logic [3:0]  id_registerY;
    logic        id_useX;
    logic        id_useY;
    logic [3:0]  id_registerZ;
    logic        id_isLoad;
    logic [2:0]  jumpControl;
    logic        ex_taken;
    logic        stall;
    logic        flush;
    logic [1:0]  fwdX;
    logic [1:0]  fwdY;
    logic [15:0] stallCount;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_registerX (id_registerX),
        .id_registerY (id_registerY),
        .id_useX      (id_useX),
        .id_useY      (id_useY),
        .id_registerZ (id_registerZ),
        .id_isLoad    (id_isLoad),
        .jumpControl  (jumpControl),
        .ex_taken     (ex_taken),
        .stall        (stall),
        .flush        (flush),
        .fwdX         (fwdX),
        .fwdY         (fwdY),
        .stallCount   (stallCount)
    );

    task automatic drive(input logic v, input logic [3:0] x, input logic ux,
                         input logic [3:0] y, input logic uy, input logic [3:0] z,
                         input logic ld, input logic [2:0] jc, input logic tk);
        id_valid = v; id_registerX = x; id_useX = ux; id_registerY = y; id_useY = uy;
        id_registerZ = z; id_isLoad = ld; jumpControl = jc; ex_taken = tk;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'h3, 1'b1, 4'h4, 1'b1, 4'h3, 1'b1, 3'd1, 1'b1);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
        next_cycle();
        next_cycle();
        total++; if (fwdX !== 2'b00) begin bad++; $display("FAIL reset_fwdX got=%b want=00", fwdX); end
        total++; if (fwdY !== 2'b00) begin bad++; $display("FAIL reset_fwdY got=%b want=00", fwdY); end
        total++; if (stallCount !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stallCount); end
        rst = 1'b0;
        idle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL post_reset_stall got=%b want=0", stall); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL post_reset_flush got=%b want=0", flush); end
        total++; if (stallCount !== 16'd0) begin bad++; $display("FAIL post_reset_count got=%0d want=0", stallCount); end
    endtask

    // Writer Z=5, then a reader of r5 held in ID.
    task automatic test_raw_stall();
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h5, 1'b0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h5, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            total++; if (stall !== !FWD_ON) begin bad++; $display("FAIL raw_stall_c%0d got=%b want=%b", c, stall, !FWD_ON); end
            if (!FWD_ON) begin
                total++; if (fwdX !== 2'b00) begin bad++; $display("FAIL raw_fwdX_c%0d got=%b want=00", c, fwdX); end
            end else begin
                total++; if (fwdX !== 2'(c + 1)) begin bad++; $display("FAIL raw_fwdX_c%0d got=%b want=%0d", c, fwdX, c + 1); end
            end
            next_cycle();
        end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_stall_end got=%b want=0", stall); end
        total++; if (fwdX !== 2'b00) begin bad++; $display("FAIL raw_fwdX_end got=%b want=00", fwdX); end
        total++; if (stallCount !== (FWD_ON ? 16'd0 : 16'd3)) begin bad++; $display("FAIL raw_count got=%0d want=%0d", stallCount, FWD_ON ? 0 : 3); end
    endtask

    // Register 0 is real, unused sources and invalid writers never match.
    task automatic test_match_rules();
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        total++; if (stall !== !FWD_ON) begin bad++; $display("FAIL r0_stall got=%b want=%b", stall, !FWD_ON); end
        total++; if (fwdX !== (FWD_ON ? 2'b01 : 2'b00)) begin bad++; $display("FAIL r0_fwdX got=%b", fwdX); end
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h4, 1'b0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h4, 1'b0, 4'h4, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL nouse_stall got=%b want=0", stall); end
        total++; if (fwdY !== 2'b00) begin bad++; $display("FAIL nouse_fwdY got=%b want=00", fwdY); end
        do_reset();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h6, 1'b1, 4'h6, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL invalid_writer_stall got=%b want=0", stall); end
        total++; if (fwdX !== 2'b00) begin bad++; $display("FAIL invalid_writer_fwdX got=%b want=00", fwdX); end
    endtask

    // Branch, then addu Z=7 in ID while resolving, then a reader of r7.
    task automatic test_branch(input logic taken);
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 3'd1, 1'b0);
        next_cycle();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 3'd0, taken);
        total++; if (flush !== taken) begin bad++; $display("FAIL br%0b_flush got=%b want=%b", taken, flush, taken); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL br%0b_stall got=%b want=0", taken, stall); end
        next_cycle();
        drive(1'b1, 4'h7, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b1);
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL br%0b_flush_after got=%b want=0", taken, flush); end
        if (taken) begin
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL br1_bubbled_stall got=%b want=0", stall); end
            total++; if (fwdX !== 2'b00) begin bad++; $display("FAIL br1_bubbled_fwdX got=%b want=00", fwdX); end
        end else begin
            total++; if (stall !== !FWD_ON) begin bad++; $display("FAIL br0_proceed_stall got=%b want=%b", stall, !FWD_ON); end
            total++; if (fwdX !== (FWD_ON ? 2'b01 : 2'b00)) begin bad++; $display("FAIL br0_proceed_fwdX got=%b", fwdX); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h5, 1'b0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h5, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        next_cycle();
        total++; if (stall !== !FWD_ON) begin bad++; $display("FAIL midrst_pre_stall got=%b want=%b", stall, !FWD_ON); end
        total++; if (stallCount !== (FWD_ON ? 16'd0 : 16'd1)) begin bad++; $display("FAIL midrst_pre_count got=%0d", stallCount); end
        rst = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL midrst_hold_stall got=%b want=0", stall); end
        total++; if (stallCount !== 16'd0) begin bad++; $display("FAIL midrst_hold_count got=%0d want=0", stallCount); end
        next_cycle();
        rst = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", stall); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL midrst_flush got=%b want=0", flush); end
        total++; if (stallCount !== 16'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", stallCount); end
        total++; if (fwdX !== 2'b00) begin bad++; $display("FAIL midrst_fwdX got=%b want=00", fwdX); end
    endtask

    // Branch carrying a load tag for r2 sits in EX while a reader of r2 is in ID.
    task automatic test_flush_wins();
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b1, 3'd1, 1'b0);
        next_cycle();
        drive(1'b1, 4'h0, 1'b0, 4'h2, 1'b1, 4'hF, 1'b0, 3'd0, 1'b1);
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL fw_flush got=%b want=1", flush); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fw_stall got=%b want=0", stall); end
        next_cycle();
        total++; if (stallCount !== 16'd0) begin bad++; $display("FAIL fw_count got=%0d want=0", stallCount); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL fw_flush_after got=%b want=0", flush); end
        total++; if (stall !== !FWD_ON) begin bad++; $display("FAIL fw_stall_after got=%b want=%b", stall, !FWD_ON); end
        total++; if (fwdY !== (FWD_ON ? 2'b10 : 2'b00)) begin bad++; $display("FAIL fw_fwdY_after got=%b", fwdY); end
    endtask

`ifdef HAZARD_FORWARD_EN
    task automatic test_forward_alu();
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b0, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall); end
        total++; if (fwdX !== 2'b01) begin bad++; $display("FAIL alu_fwdX_ex got=%b want=01", fwdX); end
        next_cycle();
        drive(1'b1, 4'h3, 1'b1, 4'h3, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        total++; if (fwdX !== 2'b10) begin bad++; $display("FAIL alu_fwdX_mem got=%b want=10", fwdX); end
        total++; if (fwdY !== 2'b10) begin bad++; $display("FAIL alu_fwdY_mem got=%b want=10", fwdY); end
        next_cycle();
        total++; if (fwdX !== 2'b11) begin bad++; $display("FAIL alu_fwdX_wb got=%b want=11", fwdX); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b1, 3'd0, 1'b0);
        next_cycle();
        drive(1'b1, 4'h0, 1'b0, 4'h2, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall); end
        next_cycle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_end got=%b want=0", stall); end
        total++; if (fwdY !== 2'b10) begin bad++; $display("FAIL lu_fwdY got=%b want=10", fwdY); end
        total++; if (stallCount !== 16'd1) begin bad++; $display("FAIL lu_count got=%0d want=1", stallCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_raw_stall();
        test_match_rules();
        test_branch(1'b1);
        test_branch(1'b0);
        test_reset_mid_stall();
        test_flush_wins();
`ifdef HAZARD_FORWARD_EN
        test_forward_alu();
        test_load_use();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_registerX, id_registerY  in  4 each  source register IDs.
REQ-005 id_useX, id_useY  in  1 each  corresponding source is actually read; register 0 is a real register, so the ID value alone is not enough.
REQ-006 id_registerZ  in  4  destination register ID; 4'hF = no write.
REQ-007 id_isLoad  in  1  ID instruction is lw or lw_sp.
REQ-008 jumpControl  in  3  decoder branch class: 0 IDLE, 1 EQZ, 2 NEZ, 3 TEQZ, 4 TNEZ, 5 JUMP, 6 DB.
REQ-009 ex_taken  in  1  branch outcome from EX; valid only in state RESOLVE.
REQ-010 stall  out  1  hold PC and IF/ID; insert a bubble into EX.
REQ-011 flush  out  1  kill the instruction in IF/ID.
REQ-012 fwdX, fwdY  out  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-013 stallCount  out  16  count of stall cycles.

Function
REQ-014 Tag pipe: three stages EX, MEM, WB, each holding {dest[3:0], isLoad}; bubble = {4'hF, 0}.
REQ-015 Each cycle the tag pipe shifts ID->EX->MEM->WB; the ID tag is {id_registerZ, id_isLoad}.
REQ-016 The ID tag is replaced by a bubble when id_valid=0, stall=1 or flush=1.
REQ-017 A source matches a stage when use=1, the stage dest != 4'hF, and dest == the source ID.
REQ-018 Forwarding enabled: stall=1 iff a used source matches the EX stage and EX.isLoad=1 (load-use, 1-cycle stall).
REQ-019 Forwarding enabled: fwd selects the youngest matching stage (EX over MEM over WB); no match gives 00.
REQ-020 Forwarding disabled: stall=1 while any used source matches EX, MEM or WB (stall lasts up to 3 cycles); fwdX and fwdY stay 00.
REQ-021 All stall, flush and fwd outputs are combinational from the state, the tags and the ID inputs, in the same cycle.
REQ-022 FSM states are RUN and RESOLVE.
REQ-023 RUN -> RESOLVE when id_valid=1, jumpControl != 0, stall=0 and flush=0 (the branch enters EX).
REQ-024 In RESOLVE, flush = ex_taken for exactly one cycle; the next state is RUN unconditionally.
REQ-025 A branch in ID during RESOLVE with ex_taken=1 is flushed and does not re-enter RESOLVE.
REQ-026 Simultaneous flush and stall: flush wins; stall is forced to 0.
REQ-027 stallCount increments on every cycle with stall=1 and saturates at 16'hFFFF.

Reset
REQ-028 rst=1 at any clock edge, including mid-stall or in RESOLVE: state=RUN, all tags=bubble, stallCount=0.
REQ-029 While rst=1, all outputs are 0.

Configuration
REQ-030 The macro HAZARD_FORWARD_EN selects the hazard policy.
REQ-031 HAZARD_FORWARD_EN defined: REQ-018 and REQ-019 apply.
REQ-032 HAZARD_FORWARD_EN undefined: REQ-020 applies and the forwarding muxes are not built.

Structure
REQ-033 Shared package hazard_pkg holds the following items.
REQ-034 hazard_pkg: NO_REG = 4'hF and the state enum {RUN, RESOLVE}.
REQ-035 hazard_pkg: fwd codes FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
REQ-036 hazard_pkg: the jumpControl encodings IDLE..DB.
REQ-037 Sub-module hazard_tag_pipe implements the 3-stage tag shift register with bubble insert and sync reset.

Verification
REQ-038 Forwarding on: issue addu Z=3, then X=3 use=1 -> stall=0, fwdX=01; on the next instruction reading r3, fwdX=10.
REQ-039 Forwarding on: lw Z=2, isLoad=1, then Y=2 use=1 -> stall=1 for exactly 1 cycle, then fwdY=10, stallCount=1.
REQ-040 Forwarding off: addu Z=5, then X=5 -> stall=1 for 3 cycles, fwdX=00 throughout, stallCount=3.
REQ-041 beqz issued (jumpControl=1), next cycle ex_taken=1 -> flush=1 for 1 cycle, ID tag bubbled, state back to RUN.
REQ-042 Same as REQ-041 with ex_taken=0 -> flush=0; the ID instruction proceeds.
REQ-043 rst=1 asserted during a 3-cycle stall -> next cycle stall=0, flush=0, stallCount=0, and a subsequent X=5 read causes no stall.
REQ-044 Flush and load-use stall in the same cycle -> flush=1, stall=0, stallCount unchanged.
